fifo_axis_packer: RTL and testbench

Drain-side stage for the synchronous show-ahead FIFO. It pops narrow FIFO words, packs RATIO of them into one wide AXI4-Stream beat, and frames packets with `tlast` every PKT_BEATS beats. A partial beat is flushed, with `tkeep` and `tlast`, when the FIFO stays dry for TIMEOUT cycles. It sits directly downstream of the FIFO: its empty flag and data output feed this block, and its read strobe drives the FIFO's read input.

---
 rtl/fifo_axis_packer_pkg.sv | 22 ++
 rtl/fifo_axis_packer_if.sv | 26 ++
 rtl/axis_out_reg.sv | 48 ++++
 rtl/fifo_axis_packer.sv | 159 +++++++++++++++
 tb/tb_fifo_axis_packer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_axis_packer_pkg.sv
// Shared types and elaboration-time helpers for the FIFO-to-AXI4-Stream packer.
package fifo_axis_packer_pkg;

  typedef enum logic [1:0] {StIdle, StFill, StFull} pack_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result = 0;
    int unsigned span = 1;
    while (span < value) begin
      span = span << 1;
      result++;
    end
    return result;
  endfunction

  // Bits needed to hold 0..max_value, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_value);
    int unsigned w = clog2(max_value + 1);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/fifo_axis_packer_if.sv
// FIFO drain side plus AXI4-Stream master side of the packer, bundled as one interface.
interface fifo_axis_packer_if #(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned RATIO      = 4
) ();

  logic                          fifo_empty_i;
  logic [FIFO_WIDTH-1:0]         fifo_dout_i;
  logic                          fifo_rd_o;
  logic                          m_tvalid_o;
  logic                          m_tready_i;
  logic [RATIO*FIFO_WIDTH-1:0]   m_tdata_o;
  logic [RATIO-1:0]              m_tkeep_o;
  logic                          m_tlast_o;

  modport master (
    input  fifo_empty_i, fifo_dout_i, m_tready_i,
    output fifo_rd_o, m_tvalid_o, m_tdata_o, m_tkeep_o, m_tlast_o
  );

  modport slave (
    output fifo_empty_i, fifo_dout_i, m_tready_i,
    input  fifo_rd_o, m_tvalid_o, m_tdata_o, m_tkeep_o, m_tlast_o
  );

endinterface

// File: rtl/axis_out_reg.sv
// Single-entry stream holding register: payload is frozen while valid and not yet accepted.
module axis_out_reg #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned KeepWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 resetz_i,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [KeepWidth-1:0] keep_i,
  input  logic                 last_i,
  input  logic                 ready_i,
  output logic                 free_o,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  output logic [KeepWidth-1:0] keep_o,
  output logic                 last_o
);

  logic                 valid_q;
  logic [DataWidth-1:0] data_q;
  logic [KeepWidth-1:0] keep_q;
  logic                 last_q;

  assign free_o = !valid_q || ready_i;

  always_ff @(posedge clk_i or negedge resetz_i) begin
    if (!resetz_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i && free_o) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule

// File: rtl/fifo_axis_packer.sv
// Pops narrow show-ahead FIFO words, packs RATIO per AXI4-Stream beat, frames packets with tlast
// and flushes a partial beat after TIMEOUT dry cycles.
module fifo_axis_packer
  import fifo_axis_packer_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned RATIO      = 4,
  parameter int unsigned PKT_BEATS  = 16,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic                clk_i,
  input logic                resetz_i,
  fifo_axis_packer_if.master bus
);

  localparam int unsigned DataW  = RATIO * FIFO_WIDTH;
  localparam int unsigned WcntW  = cnt_width(RATIO);
  localparam int unsigned BeatW  = (clog2(PKT_BEATS) > 0) ? clog2(PKT_BEATS) : 1;
  localparam int unsigned IdleW  = cnt_width(TIMEOUT);
  localparam bit          FlushEn = (TIMEOUT != 0);

  localparam logic [WcntW-1:0] WcntFull = WcntW'(RATIO);
  localparam logic [WcntW-1:0] WcntLast = WcntW'(RATIO - 1);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(PKT_BEATS - 1);
  localparam logic [IdleW-1:0] IdleMax  = IdleW'(TIMEOUT);
  localparam logic [IdleW-1:0] IdleLast = IdleW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [RATIO-1:0][FIFO_WIDTH-1:0] pack_q, pack_d;
  logic [WcntW-1:0]                 wcnt_q, wcnt_d;
  logic [BeatW-1:0]                 beat_q, beat_d;
  logic [IdleW-1:0]                 idle_q, idle_d;

  pack_state_e                      state;
  logic                             out_free;
  logic                             pop;
  logic                             load;
  logic [RATIO-1:0][FIFO_WIDTH-1:0] ld_data;
  logic [RATIO-1:0]                 ld_keep;
  logic                             ld_last;
  logic                             beat_last;
  logic [BeatW-1:0]                 beat_next;

  always_comb begin
    if (wcnt_q == '0) begin
      state = StIdle;
    end else if (wcnt_q == WcntFull) begin
      state = StFull;
    end else begin
      state = StFill;
    end
  end

  // Gated by reset so the strobe is low the instant reset asserts.
  assign pop = resetz_i && !bus.fifo_empty_i && ((state != StFull) || out_free);
  assign bus.fifo_rd_o = pop;

  assign beat_last = (beat_q == BeatLast);
  assign beat_next = beat_last ? '0 : beat_q + 1'b1;

  always_comb begin
    pack_d  = pack_q;
    wcnt_d  = wcnt_q;
    beat_d  = beat_q;
    idle_d  = '0;
    load    = 1'b0;
    ld_data = '0;
    ld_keep = '0;
    ld_last = 1'b0;

    unique case (state)
      StIdle, StFill: begin
        if (pop) begin
          for (int unsigned i = 0; i < RATIO; i++) begin
            if (wcnt_q == WcntW'(i)) pack_d[i] = bus.fifo_dout_i;
          end
          if (wcnt_q == WcntLast) begin
            // Completing word goes straight to the output when it can, avoiding a FULL cycle.
            if (out_free) begin
              load    = 1'b1;
              ld_data = pack_d;
              ld_keep = '1;
              ld_last = beat_last;
              beat_d  = beat_next;
              wcnt_d  = '0;
            end else begin
              wcnt_d = WcntFull;
            end
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end else if (state == StFill) begin
          if (FlushEn && out_free && (idle_q >= IdleLast)) begin
            load    = 1'b1;
            ld_last = 1'b1;
            for (int unsigned i = 0; i < RATIO; i++) begin
              if (WcntW'(i) < wcnt_q) begin
                ld_data[i] = pack_q[i];
                ld_keep[i] = 1'b1;
              end
            end
            beat_d = '0;
            wcnt_d = '0;
          end else begin
            idle_d = (idle_q < IdleMax) ? idle_q + 1'b1 : idle_q;
          end
        end
      end
      StFull: begin
        if (out_free) begin
          load    = 1'b1;
          ld_data = pack_q;
          ld_keep = '1;
          ld_last = beat_last;
          beat_d  = beat_next;
          if (pop) begin
            pack_d[0] = bus.fifo_dout_i;
            wcnt_d    = WcntW'(1);
          end else begin
            wcnt_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetz_i) begin
    if (!resetz_i) begin
      pack_q <= '0;
      wcnt_q <= '0;
      beat_q <= '0;
      idle_q <= '0;
    end else begin
      pack_q <= pack_d;
      wcnt_q <= wcnt_d;
      beat_q <= beat_d;
      idle_q <= idle_d;
    end
  end

  axis_out_reg #(
    .DataWidth(DataW),
    .KeepWidth(RATIO)
  ) u_out_reg (
    .clk_i   (clk_i),
    .resetz_i(resetz_i),
    .load_i  (load),
    .data_i  (ld_data),
    .keep_i  (ld_keep),
    .last_i  (ld_last),
    .ready_i (bus.m_tready_i),
    .free_o  (out_free),
    .valid_o (bus.m_tvalid_o),
    .data_o  (bus.m_tdata_o),
    .keep_o  (bus.m_tkeep_o),
    .last_o  (bus.m_tlast_o)
  );

endmodule

// File: tb/tb_fifo_axis_packer.sv
// Directed bench for fifo_axis_packer with a queue standing in for the show-ahead FIFO.
module tb_fifo_axis_packer;

  logic clk = 1'b0;
  logic resetz = 1'b0;
  always #5 clk = ~clk;

  fifo_axis_packer_if #(.FIFO_WIDTH(8), .RATIO(4)) bus ();

  fifo_axis_packer #(
    .FIFO_WIDTH(8),
    .RATIO     (4),
    .PKT_BEATS (2),
    .TIMEOUT   (8)
  ) dut (
    .clk_i   (clk),
    .resetz_i(resetz),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [7:0]  w [4];
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] fifo_q [$];
  beat_t      got [$];
  int         beat_cyc [$];
  int         pop_cyc [$];
  logic [7:0] words [64];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        s_rd, s_valid, s_last;
  logic [31:0] s_data;
  logic [3:0]  s_keep;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic [31:0] data,
                         input logic last);
    vecs[i].w[0] = a;
    vecs[i].w[1] = b;
    vecs[i].w[2] = c;
    vecs[i].w[3] = d;
    vecs[i].data = data;
    vecs[i].keep = 4'hF;
    vecs[i].last = last;
  endtask

  task automatic drive_fifo();
    bus.fifo_empty_i = (fifo_q.size() == 0);
    bus.fifo_dout_i  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  // Entered at a falling edge; samples just after it and returns at the next falling edge.
  task automatic tick();
    drive_fifo();
    #1;
    s_rd    = bus.fifo_rd_o;
    s_valid = bus.m_tvalid_o;
    s_data  = bus.m_tdata_o;
    s_keep  = bus.m_tkeep_o;
    s_last  = bus.m_tlast_o;
    if (bus.fifo_empty_i) check("rd_while_empty", {31'd0, s_rd}, 32'd0);
    if (s_valid && bus.m_tready_i) begin
      got.push_back('{data: s_data, keep: s_keep, last: s_last});
      beat_cyc.push_back(cyc);
    end
    if (s_rd && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_log();
    got.delete();
    beat_cyc.delete();
    pop_cyc.delete();
  endtask

  task automatic run_beats(input int n, input int budget, input string name);
    int k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    check($sformatf("%s_beat_count", name), got.size(), n);
  endtask

  task automatic check_beat(input string name, input int idx, input logic [31:0] data,
                            input logic [3:0] keep, input logic last);
    if (idx < got.size()) begin
      check($sformatf("%s_data", name), got[idx].data, data);
      check($sformatf("%s_keep", name), {28'd0, got[idx].keep}, {28'd0, keep});
      check($sformatf("%s_last", name), {31'd0, got[idx].last}, {31'd0, last});
    end else begin
      check($sformatf("%s_present", name), got.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int k;
    int gaps;
    int stable_err;
    logic seen;
    logic [31:0] held;
    logic [31:0] exp;

    set_vec(0, 8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 1'b0);
    set_vec(1, 8'h05, 8'h06, 8'h07, 8'h08, 32'h08070605, 1'b1);
    set_vec(2, 8'hA5, 8'h5A, 8'hFF, 8'h00, 32'h00FF5AA5, 1'b0);
    set_vec(3, 8'h10, 8'h20, 8'h30, 8'h40, 32'h40302010, 1'b1);
    set_vec(4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE, 1'b0);
    set_vec(5, 8'h00, 8'h00, 8'h00, 8'h80, 32'h80000000, 1'b1);

    // Reset state, with a non-empty FIFO so the read gate matters.
    bus.fifo_empty_i = 1'b0;
    bus.fifo_dout_i  = 8'h5C;
    bus.m_tready_i   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_tvalid", {31'd0, bus.m_tvalid_o}, 32'd0);
    check("reset_tdata", bus.m_tdata_o, 32'd0);
    check("reset_tkeep", {28'd0, bus.m_tkeep_o}, 32'd0);
    check("reset_tlast", {31'd0, bus.m_tlast_o}, 32'd0);
    check("reset_rd", {31'd0, bus.fifo_rd_o}, 32'd0);
    @(negedge clk);
    resetz = 1'b1;

    // Table-driven streaming, including basic packing of 0x01..0x08.
    clear_log();
    bus.m_tready_i = 1'b1;
    for (int v = 0; v < 6; v++) begin
      for (int w = 0; w < 4; w++) fifo_q.push_back(vecs[v].w[w]);
    end
    run_beats(6, 60, "tbl");
    for (int v = 0; v < 6; v++) begin
      check_beat($sformatf("tbl%0d", v), v, vecs[v].data, vecs[v].keep, vecs[v].last);
      if (v < beat_cyc.size() && 4 * v + 3 < pop_cyc.size())
        check($sformatf("tbl%0d_latency", v), beat_cyc[v] - pop_cyc[4 * v + 3], 1);
    end

    // Backpressure: one beat held, pack fills, FIFO keeps the rest.
    clear_log();
    bus.m_tready_i = 1'b0;
    for (int i = 0; i < 12; i++) fifo_q.push_back(8'(8'h21 + i));
    stable_err = 0;
    seen = 1'b0;
    held = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_valid) begin
        if (!seen) begin
          held = s_data;
          seen = 1'b1;
        end else if (s_data !== held || s_keep !== 4'hF || s_last !== 1'b0) begin
          stable_err++;
        end
      end
    end
    check("bp_valid", {31'd0, s_valid}, 32'd1);
    check("bp_data", s_data, 32'h24232221);
    check("bp_stable", stable_err, 0);
    check("bp_rd", {31'd0, s_rd}, 32'd0);
    check("bp_fifo_left", fifo_q.size(), 4);
    bus.m_tready_i = 1'b1;
    run_beats(3, 30, "bp");
    check_beat("bp0", 0, 32'h24232221, 4'hF, 1'b0);
    check_beat("bp1", 1, 32'h28272625, 4'hF, 1'b1);
    check_beat("bp2", 2, 32'h2C2B2A29, 4'hF, 1'b0);

    // Timeout flush of a three-word partial beat, then a full beat with framing restarted.
    clear_log();
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h03);
    run_beats(1, 30, "to");
    check_beat("to_flush", 0, 32'h00030201, 4'h7, 1'b1);
    if (beat_cyc.size() > 0 && pop_cyc.size() > 2)
      check("to_delay", beat_cyc[0] - pop_cyc[2], 9);
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h31 + i));
    run_beats(2, 20, "to_next");
    check_beat("to_next", 1, 32'h34333231, 4'hF, 1'b0);

    // A pop in the cycle the idle count matures wins over the flush.
    clear_log();
    for (int i = 0; i < 3; i++) fifo_q.push_back(8'(8'h41 + i));
    k = 0;
    while (pop_cyc.size() < 3 && k < 10) begin
      tick();
      k++;
    end
    repeat (7) tick();
    fifo_q.push_back(8'h44);
    run_beats(1, 20, "prio");
    check_beat("prio", 0, 32'h44434241, 4'hF, 1'b1);
    if (pop_cyc.size() > 3) check("prio_pop_gap", pop_cyc[3] - pop_cyc[2], 8);

    // Empty FIFO throughout with random ready.
    clear_log();
    for (int i = 0; i < 150; i++) begin
      bus.m_tready_i = 1'($urandom_range(0, 1));
      tick();
    end
    check("empty_no_beats", got.size(), 0);
    check("empty_no_pops", pop_cyc.size(), 0);

    // Mid-packet asynchronous reset with a held beat and a two-word partial pack.
    clear_log();
    bus.m_tready_i = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h61 + i));
    fifo_q.push_back(8'h51);
    fifo_q.push_back(8'h52);
    fifo_q.push_back(8'h99);
    k = 0;
    while (pop_cyc.size() < 6 && k < 20) begin
      tick();
      k++;
    end
    drive_fifo();
    #2;
    check("rst_pre_valid", {31'd0, bus.m_tvalid_o}, 32'd1);
    check("rst_pre_rd", {31'd0, bus.fifo_rd_o}, 32'd1);
    resetz = 1'b0;
    #1;
    check("rst_tvalid", {31'd0, bus.m_tvalid_o}, 32'd0);
    check("rst_tdata", bus.m_tdata_o, 32'd0);
    check("rst_tkeep", {28'd0, bus.m_tkeep_o}, 32'd0);
    check("rst_tlast", {31'd0, bus.m_tlast_o}, 32'd0);
    check("rst_rd", {31'd0, bus.fifo_rd_o}, 32'd0);
    fifo_q.delete();
    @(negedge clk);
    @(negedge clk);
    resetz = 1'b1;
    clear_log();
    bus.m_tready_i = 1'b1;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h11 + i));
    run_beats(2, 20, "rst_after");
    check_beat("rst_after0", 0, 32'h14131211, 4'hF, 1'b0);
    check_beat("rst_after1", 1, 32'h18171615, 4'hF, 1'b1);

    // Sustained back-to-back streaming of 64 words.
    clear_log();
    for (int i = 0; i < 64; i++) begin
      words[i] = 8'(i * 7 + 3);
      fifo_q.push_back(words[i]);
    end
    gaps = 0;
    k = 0;
    while (got.size() < 16 && k < 120) begin
      tick();
      if (!bus.fifo_empty_i && !s_rd) gaps++;
      k++;
    end
    check("sus_beat_count", got.size(), 16);
    check("sus_rd_gaps", gaps, 0);
    if (pop_cyc.size() == 64) check("sus_pop_span", pop_cyc[63] - pop_cyc[0], 63);
    for (int b = 0; b < 16; b++) begin
      exp = {words[4 * b + 3], words[4 * b + 2], words[4 * b + 1], words[4 * b]};
      check_beat($sformatf("sus%0d", b), b, exp, 4'hF, 1'(b % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
